// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues instruction-memory reads and drives the
// IF/ID register. Handles stalls, EX redirects and memory wait states.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic        o_imem_read,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_readdata,
    input  logic        i_imem_busy,
    output logic [31:0] o_pc_id,
    output logic [31:0] o_pc_plus4_id,
    output logic [31:0] o_instruction_id,
    output logic        o_valid_id
);

    typedef enum logic {StFetch, StDiscard} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redirect_pc;
    logic        r_fetch_en;
    logic [31:0] r_pc_id;
    logic [31:0] r_pc_plus4_id;
    logic [31:0] r_instruction_id;
    logic        r_valid_id;

    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    assign w_target   = i_branch_target & ~32'd3;
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= StFetch;
            r_pc             <= RESET_PC;
            r_redirect_pc    <= 32'd0;
            r_fetch_en       <= 1'b0;
            r_pc_id          <= 32'd0;
            r_pc_plus4_id    <= 32'd0;
            r_instruction_id <= BUBBLE_INSTR;
            r_valid_id       <= 1'b0;
        end else begin
            r_fetch_en <= 1'b1;
            unique case (r_state)
                StFetch: begin
                    if (i_branch_taken) begin
                        r_instruction_id <= BUBBLE_INSTR;
                        r_valid_id       <= 1'b0;
                        if (!i_imem_busy) begin
                            r_pc <= w_target;
                        end else begin
                            // The busy fetch cannot be aborted; park the target until it retires.
                            r_redirect_pc <= w_target;
                            r_state       <= StDiscard;
                        end
                    end else if (!r_fetch_en || i_stall) begin
                        r_pc <= r_pc;
                    end else if (i_imem_busy) begin
                        r_instruction_id <= BUBBLE_INSTR;
                        r_valid_id       <= 1'b0;
                    end else begin
                        r_pc_id          <= r_pc;
                        r_pc_plus4_id    <= w_pc_plus4;
                        r_instruction_id <= i_imem_readdata;
                        r_valid_id       <= 1'b1;
                        r_pc             <= w_pc_plus4;
                    end
                end
                StDiscard: begin
                    r_instruction_id <= BUBBLE_INSTR;
                    r_valid_id       <= 1'b0;
                    if (i_branch_taken) begin
                        r_redirect_pc <= w_target;
                    end
                    if (!i_imem_busy) begin
                        r_pc    <= i_branch_taken ? w_target : r_redirect_pc;
                        r_state <= StFetch;
                    end
                end
                default: r_state <= StFetch;
            endcase
        end
    end

    assign o_imem_read      = r_fetch_en;
    assign o_imem_addr      = r_pc;
    assign o_pc_id          = r_pc_id;
    assign o_pc_plus4_id    = r_pc_plus4_id;
    assign o_instruction_id = r_instruction_id;
    assign o_valid_id       = r_valid_id;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, async-reset sequence and
// randomized traffic against a behavioural fetch model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        busy;
    logic [31:0] pc_id;
    logic [31:0] pc_plus4_id;
    logic [31:0] instr_id;
    logic        valid_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    instruction_fetch_unit dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_stall          (stall),
        .i_branch_taken   (br),
        .i_branch_target  (tgt),
        .o_imem_read      (imem_read),
        .o_imem_addr      (imem_addr),
        .i_imem_readdata  (imem_rdata),
        .i_imem_busy      (busy),
        .o_pc_id          (pc_id),
        .o_pc_plus4_id    (pc_plus4_id),
        .o_instruction_id (instr_id),
        .o_valid_id       (valid_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " read"},  {31'd0, imem_read}, 32'd0);
        check({tag, " addr"},  imem_addr, 32'd0);
        check({tag, " pc_id"}, pc_id, 32'd0);
        check({tag, " plus4"}, pc_plus4_id, 32'd0);
        check({tag, " instr"}, instr_id, 32'd0);
        check({tag, " valid"}, {31'd0, valid_id}, 32'd0);
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        busy;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc_id;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic b, input logic [31:0] t, input logic bz,
                       input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.busy = bz;
        v.exp_addr = ea; v.exp_valid = ev; v.exp_pc_id = ep;
        vecs.push_back(v);
    endtask

    // Behavioural model state
    logic [31:0] m_pc, m_redirect, m_pc_id, m_plus4, m_instr;
    logic        m_valid, m_started, m_wrong_path;

    task automatic model_reset();
        m_pc = 32'd0; m_redirect = 32'd0; m_pc_id = 32'd0; m_plus4 = 32'd0;
        m_instr = 32'd0; m_valid = 1'b0; m_started = 1'b0; m_wrong_path = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic b, input logic [31:0] t,
                              input logic bz);
        logic [31:0] at;
        at = {t[31:2], 2'b00};
        if (m_wrong_path) begin
            m_valid = 1'b0; m_instr = 32'd0;
            if (b) m_redirect = at;
            if (!bz) begin
                m_pc = m_redirect;
                m_wrong_path = 1'b0;
            end
        end else if (b) begin
            m_valid = 1'b0; m_instr = 32'd0;
            if (bz) begin
                m_wrong_path = 1'b1;
                m_redirect = at;
            end else begin
                m_pc = at;
            end
        end else if (m_started && !s) begin
            if (bz) begin
                m_valid = 1'b0; m_instr = 32'd0;
            end else begin
                m_pc_id = m_pc; m_plus4 = m_pc + 32'd4;
                m_instr = mem_word(m_pc); m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
        m_started = 1'b1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'd0; busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // stall, br, tgt, busy  |  exp addr, valid, pc_id (after the edge)
        add(0, 0, 0,            0, 32'h0,        0, 32'h0);
        add(0, 0, 0,            0, 32'h4,        1, 32'h0);
        add(0, 0, 0,            0, 32'h8,        1, 32'h4);
        add(0, 0, 0,            0, 32'hC,        1, 32'h8);
        add(0, 0, 0,            0, 32'h10,       1, 32'hC);
        add(1, 0, 0,            0, 32'h10,       1, 32'hC);
        add(1, 0, 0,            0, 32'h10,       1, 32'hC);
        add(1, 0, 0,            0, 32'h10,       1, 32'hC);
        add(0, 0, 0,            0, 32'h14,       1, 32'h10);
        add(0, 0, 0,            0, 32'h18,       1, 32'h14);
        add(0, 0, 0,            0, 32'h1C,       1, 32'h18);
        add(0, 0, 0,            0, 32'h20,       1, 32'h1C);
        add(1, 1, 32'h102,      0, 32'h100,      0, 32'h1C);
        add(0, 0, 0,            0, 32'h104,      1, 32'h100);
        add(0, 1, 32'h40,       0, 32'h40,       0, 32'h100);
        add(0, 1, 32'h80,       1, 32'h40,       0, 32'h100);
        add(0, 0, 0,            1, 32'h40,       0, 32'h100);
        add(0, 0, 0,            0, 32'h80,       0, 32'h100);
        add(0, 0, 0,            0, 32'h84,       1, 32'h80);
        add(0, 1, 32'h200,      1, 32'h84,       0, 32'h80);
        add(1, 1, 32'hC0,       1, 32'h84,       0, 32'h80);
        add(1, 0, 0,            0, 32'hC0,       0, 32'h80);
        add(0, 0, 0,            0, 32'hC4,       1, 32'hC0);
        add(0, 0, 0,            1, 32'hC4,       0, 32'hC0);
        add(0, 0, 0,            0, 32'hC8,       1, 32'hC4);
        add(0, 1, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFC, 0, 32'hC4);
        add(0, 0, 0,            0, 32'h0,        1, 32'hFFFF_FFFC);
        add(0, 1, 32'h300,      0, 32'h300,      0, 32'hFFFF_FFFC);
        add(1, 0, 0,            0, 32'h300,      0, 32'hFFFF_FFFC);
        add(0, 0, 0,            0, 32'h304,      1, 32'h300);

        foreach (vecs[i]) begin
            stall = vecs[i].stall; br = vecs[i].br; tgt = vecs[i].tgt; busy = vecs[i].busy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d valid", i), {31'd0, valid_id}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d pc_id", i), pc_id, vecs[i].exp_pc_id);
            check($sformatf("vec%0d plus4", i), pc_plus4_id,
                  (i == 0) ? 32'd0 : vecs[i].exp_pc_id + 32'd4);
            check($sformatf("vec%0d instr", i), instr_id,
                  vecs[i].exp_valid ? mem_word(vecs[i].exp_pc_id) : 32'd0);
        end

        // Async reset while a redirect is pending behind a busy fetch
        stall = 1'b0; br = 1'b1; tgt = 32'h500; busy = 1'b1;
        @(posedge clk);
        #1;
        check("busy redirect addr", imem_addr, 32'h304);
        br = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async reset");
        @(posedge clk);
        #1;
        rst = 1'b0; busy = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset read", {31'd0, imem_read}, 32'd1);
        check("post-reset addr", imem_addr, 32'd0);
        check("post-reset valid", {31'd0, valid_id}, 32'd0);
        @(posedge clk);
        #1;
        check("post-reset addr2", imem_addr, 32'd4);
        check("post-reset valid2", {31'd0, valid_id}, 32'd1);
        check("post-reset pc_id", pc_id, 32'd0);

        // Randomized traffic against the model
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            stall = ($urandom_range(0, 4) == 0);
            br    = ($urandom_range(0, 9) == 0);
            busy  = ($urandom_range(0, 9) < 3);
            tgt   = $urandom;
            model_step(stall, br, tgt, busy);
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d read", n), {31'd0, imem_read}, 32'd1);
            check($sformatf("rnd%0d addr", n), imem_addr, m_pc);
            check($sformatf("rnd%0d valid", n), {31'd0, valid_id}, {31'd0, m_valid});
            check($sformatf("rnd%0d pc_id", n), pc_id, m_pc_id);
            check($sformatf("rnd%0d plus4", n), pc_plus4_id, m_plus4);
            check($sformatf("rnd%0d instr", n), instr_id, m_instr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end stage of the RV32IM pipeline: owns the program counter, issues instruction-memory reads, and drives the IF/ID pipeline register that feeds the instruction decoder/control unit. Handles hazard-unit stalls, taken-branch/jump redirects from EX, and instruction-memory wait states. Squashed slots carry a bubble whose opcode is 7'b0000000, which the decoder already treats as "no register-file write".

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- BUBBLE_INSTR, 32'h0000_0000, instruction word placed in IF/ID when the slot is squashed or empty.

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge.
- RESET  in  1  reset is asynchronous and active-high.
- STALL  in  1  hazard unit: hold PC and IF/ID contents.
- BRANCH_TAKEN  in  1  EX stage: taken branch, JAL or JALR this cycle.
- BRANCH_TARGET  in  32  redirect address, valid when BRANCH_TAKEN=1.
- IMEM_READ  out  1  instruction read request.
- IMEM_ADDR  out  32  instruction read address.
- IMEM_READDATA  in  32  instruction word, valid in any cycle with IMEM_READ=1 and IMEM_BUSY=0.
- IMEM_BUSY  in  1  memory wait state; IMEM_ADDR must stay stable while high.
- PC_ID  out  32  IF/ID: PC of held instruction.
- PC_PLUS4_ID  out  32  IF/ID: PC_ID + 4 (link value).
- INSTRUCTION_ID  out  32  IF/ID: instruction word to decoder.
- VALID_ID  out  1  IF/ID: 1 = real instruction, 0 = bubble.

## Operation
- Registers: pc, redirect_pc, state ∈ {FETCH, DISCARD}, fetch_en, IF/ID set (PC_ID, PC_PLUS4_ID, INSTRUCTION_ID, VALID_ID).
- Reset (async, immediate): pc=RESET_PC, redirect_pc=0, state=FETCH, fetch_en=0, PC_ID=0, PC_PLUS4_ID=0, INSTRUCTION_ID=BUBBLE_INSTR, VALID_ID=0.
- IMEM_READ = fetch_en; fetch_en becomes 1 on the first rising edge with RESET low and stays 1. IMEM_ADDR = pc.
- Target alignment: BRANCH_TARGET[1:0] forced to 2'b00 before use. pc+4 wraps modulo 2^32.
- FETCH, per edge, in priority order:
  - BRANCH_TAKEN & !IMEM_BUSY: pc ← target; IF/ID ← bubble (VALID_ID=0, INSTRUCTION_ID=BUBBLE_INSTR, PC_ID/PC_PLUS4_ID unchanged). Overrides STALL.
  - BRANCH_TAKEN & IMEM_BUSY: redirect_pc ← target; state ← DISCARD; pc unchanged; IF/ID ← bubble.
  - fetch_en=0: no change.
  - STALL: pc and IF/ID hold.
  - IMEM_BUSY: pc holds; IF/ID ← bubble.
  - else: IF/ID ← {pc, pc+4, IMEM_READDATA, 1}; pc ← pc+4.
- DISCARD (in-flight fetch is wrong-path and cannot be aborted):
  - IF/ID held at bubble regardless of STALL.
  - BRANCH_TAKEN again: redirect_pc ← new target (latest wins).
  - IMEM_BUSY=0: returned word dropped; pc ← redirect_pc (or the new target if BRANCH_TAKEN same cycle); state ← FETCH.
- A held bubble under STALL remains a bubble; STALL never creates a valid slot.

## Timing
- Fetch latency: address presented cycle n with IMEM_BUSY=0 → INSTRUCTION_ID/VALID_ID valid from cycle n+1.
- Throughput: one instruction per cycle with no stalls, branches or wait states.
- First fetch: IMEM_READ rises the first edge after RESET deasserts; IMEM_ADDR=RESET_PC that cycle.
- Redirect, memory idle: BRANCH_TAKEN in cycle n → IMEM_ADDR=target and VALID_ID=0 in n+1; target instruction in ID at n+2.
- Redirect, memory busy: target on IMEM_ADDR the cycle after IMEM_BUSY falls; no wrong-path word ever reaches VALID_ID=1.
- IMEM_ADDR changes only on an edge where IMEM_BUSY was 0 or fetch_en was 0.
- RESET mid-transaction: all state cleared at once; pending redirect and busy fetch forgotten.

## Test plan
- Reset release, RESET_PC=0, memory never busy, no stalls → IMEM_ADDR 0,4,8,12 on consecutive cycles; PC_ID 0,4,8 one cycle later; VALID_ID=1 from the second cycle after release.
- STALL high 3 cycles while fetching 0x10 → PC_ID=0x0C and INSTRUCTION_ID frozen; IMEM_ADDR stays 0x10; resumes with PC_ID=0x10 after release.
- BRANCH_TAKEN with BRANCH_TARGET=0x0000_0102 at pc=0x20, STALL=1 → next IMEM_ADDR=0x100, VALID_ID=0; following cycle PC_ID=0x100, VALID_ID=1.
- IMEM_BUSY high 2 cycles at pc=0x40, BRANCH_TAKEN (target 0x80) in first busy cycle → IMEM_ADDR holds 0x40 while busy; data from 0x40 never appears valid; IMEM_ADDR=0x80 next cycle.
- Second BRANCH_TAKEN (target 0xC0) during DISCARD → fetch resumes at 0xC0, not 0x80.
- pc=0xFFFF_FFFC fetch → PC_PLUS4_ID=0, next IMEM_ADDR=0; async RESET asserted mid-busy → outputs at reset values before the next edge.
